// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start bit, 1..DATA_W data bits LSB first,
// optional even/odd parity, 1 or 2 stop bits, timed by the baud generator's oversampling tick.
module uart_tx_cfg #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned OS_TICK = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              s_tick_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic [3:0]        cfg_dbits_i,
  input  logic [1:0]        cfg_par_i,
  input  logic              cfg_stop2_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              tx_done_tick_o
);

  localparam int unsigned SW = $clog2(2 * OS_TICK);
  localparam logic [SW-1:0] SLast1 = SW'(OS_TICK - 1);
  localparam logic [SW-1:0] SLast2 = SW'(2 * OS_TICK - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [3:0]        n_q, n_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [3:0]        dbits_q, dbits_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  logic [3:0]        eff_dbits;
  logic [DATA_W-1:0] masked;
  logic [SW-1:0]     s_last;
  logic              tick_end;

  // Out-of-range lengths fall back to the full width; unused data bits are zeroed so the
  // parity reduction covers only the bits that go on the line.
  always_comb begin
    eff_dbits = cfg_dbits_i;
    if (cfg_dbits_i == 4'd0 || 32'(cfg_dbits_i) > DATA_W) eff_dbits = 4'(DATA_W);
    masked = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      masked[i] = tx_data_i[i] & (i < 32'(eff_dbits));
    end
  end

  assign s_last   = (state_q == StStop && stop2_q) ? SLast2 : SLast1;
  assign tick_end = s_tick_i && (s_q == s_last);

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    shreg_d   = shreg_q;
    dbits_d   = dbits_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    done_d    = 1'b0;

    if (state_q != StIdle && s_tick_i) s_d = tick_end ? '0 : s_q + SW'(1);

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (tx_valid_i) begin
          state_d   = StStart;
          s_d       = '0;
          n_d       = '0;
          tx_d      = 1'b0;
          shreg_d   = masked;
          dbits_d   = eff_dbits;
          par_en_d  = (cfg_par_i == 2'b01) || (cfg_par_i == 2'b10);
          par_bit_d = (^masked) ^ (cfg_par_i == 2'b10);
          stop2_d   = cfg_stop2_i;
        end
      end
      StStart: begin
        if (tick_end) begin
          state_d = StData;
          tx_d    = shreg_q[0];
        end
      end
      StData: begin
        if (tick_end) begin
          shreg_d = shreg_q >> 1;
          n_d     = n_q + 4'd1;
          if (n_q == dbits_q - 4'd1) begin
            state_d = par_en_q ? StParity : StStop;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            tx_d = shreg_q[1];
          end
        end
      end
      StParity: begin
        if (tick_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        if (tick_end) begin
          state_d = StIdle;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      s_q       <= '0;
      n_q       <= '0;
      shreg_q   <= '0;
      dbits_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      shreg_q   <= shreg_d;
      dbits_q   <= dbits_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign tx_ready_o     = (state_q == StIdle);
  assign busy_o         = (state_q != StIdle);
  assign tx_o           = tx_q;
  assign tx_done_tick_o = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: stimulus queues expected line patterns, a negedge
// monitor decodes each frame from the serial line and compares bit by bit.
module tb_uart_tx_cfg;

  localparam int unsigned DW = 8;
  localparam int unsigned OS = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_tick;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] tx_data = '0;
  logic [3:0]    cfg_dbits = 4'd8;
  logic [1:0]    cfg_par = 2'b00;
  logic          cfg_stop2 = 1'b0;
  logic          tx;
  logic          busy;
  logic          tx_done;

  int cnt = 0;
  int tick_div = 1;
  int checks = 0;
  int errors = 0;
  bit mon_active = 1'b0;

  // Expected frames: line pattern in transmit order, clocks per bit, start-bit shortening.
  string q_bits[$];
  int    q_p[$];
  int    q_short[$];

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;
  assign s_tick = (tick_div <= 1) || ((cnt % tick_div) == 0);

  uart_tx_cfg #(
    .DATA_W (DW),
    .OS_TICK(OS)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .s_tick_i      (s_tick),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .tx_data_i     (tx_data),
    .cfg_dbits_i   (cfg_dbits),
    .cfg_par_i     (cfg_par),
    .cfg_stop2_i   (cfg_stop2),
    .tx_o          (tx),
    .busy_o        (busy),
    .tx_done_tick_o(tx_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called from posedge+#1 context; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] data, input logic [3:0] dbits, input logic [1:0] par,
                      input logic stop2, input string bits, input int short0,
                      input bit keep, input bit align);
    int   budget;
    logic rdy;
    if (align) begin
      while (tick_div > 1 && (cnt % tick_div) != 0) begin
        @(posedge clk);
        #1;
      end
    end
    tx_data   = data;
    cfg_dbits = dbits;
    cfg_par   = par;
    cfg_stop2 = stop2;
    tx_valid  = 1'b1;
    q_bits.push_back(bits);
    q_p.push_back(OS * tick_div);
    q_short.push_back(short0);
    budget = 0;
    forever begin
      rdy = tx_ready;
      @(posedge clk);
      #1;
      budget++;
      if (rdy) break;
      if (budget > 5000) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    if (!keep) begin
      // Scramble inputs after accept: the frame in flight must not notice.
      tx_valid  = 1'b0;
      tx_data   = ~data;
      cfg_dbits = 4'd5;
      cfg_par   = ~par;
      cfg_stop2 = ~stop2;
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((mon_active || q_bits.size() != 0 || !tx_ready) && budget < 5000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("drain_timeout", {31'd0, budget >= 5000}, 32'd0);
  endtask

  task automatic idle_cycles(input int n, input string name);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad = 1'b1;
    end
    @(posedge clk);
    #1;
    check(name, {31'd0, bad}, 32'd0);
  endtask

  initial begin : monitor
    string cur;
    int    p, sh, idx, nb, j;
    bit    bad, prev_done;
    p = 1; sh = 0; idx = 0; nb = 0; bad = 1'b0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_active = 1'b0;
        prev_done  = 1'b0;
        continue;
      end
      if (!mon_active) begin
        if (tx_done) check("done_outside_frame", {31'd0, tx_done}, 32'd0);
        if (tx === 1'b0) begin
          if (q_bits.size() == 0) begin
            check("unexpected_frame", {31'd0, tx}, 32'd1);
          end else begin
            cur = q_bits.pop_front();
            p   = q_p.pop_front();
            sh  = q_short.pop_front();
            nb  = cur.len();
            idx = 0;
            bad = 1'b0;
            mon_active = 1'b1;
            if (sh > 0) check("b2b_start_after_done", {31'd0, prev_done}, 32'd1);
          end
        end
      end
      if (mon_active) begin
        if (idx < nb * p - sh) begin
          j = (idx + sh) / p;
          if (tx !== (cur.getc(j) == 8'h31) || tx_done !== 1'b0 || busy !== 1'b1 ||
              tx_ready !== 1'b0) bad = 1'b1;
          if (((idx + sh) % p) == p - 1) begin
            check($sformatf("frame_%s_bit%0d", cur, j), {31'd0, bad}, 32'd0);
            bad = 1'b0;
          end
          idx++;
        end else begin
          check($sformatf("frame_%s_done", cur), {31'd0, tx_done}, 32'd1);
          check($sformatf("frame_%s_tx_idle", cur), {31'd0, tx}, 32'd1);
          mon_active = 1'b0;
        end
      end
      prev_done = tx_done;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_ready", {31'd0, tx_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, tx_done}, 32'd0);
    reset = 1'b0;

    idle_cycles(100, "idle_100");

    // 8N1, 8E1, 8O1 with 0x55; 7O2 with 0xC1; 5E2 with 0xFF; dbits 0 and 12 fall back to 8.
    send(8'h55, 4'd8, 2'b00, 1'b0, "0101010101", 0, 1'b0, 1'b0);
    wait_idle();
    send(8'h55, 4'd8, 2'b01, 1'b0, "01010101001", 0, 1'b0, 1'b0);
    wait_idle();
    send(8'h55, 4'd8, 2'b10, 1'b0, "01010101011", 0, 1'b0, 1'b0);
    wait_idle();
    send(8'hC1, 4'd7, 2'b10, 1'b1, "01000001111", 0, 1'b0, 1'b0);
    wait_idle();
    send(8'hFF, 4'd5, 2'b01, 1'b1, "011111111", 0, 1'b0, 1'b0);
    wait_idle();
    send(8'h55, 4'd0, 2'b11, 1'b0, "0101010101", 0, 1'b0, 1'b0);
    wait_idle();
    send(8'h3C, 4'd12, 2'b00, 1'b0, "0001111001", 0, 1'b0, 1'b0);
    wait_idle();

    // Back-to-back with s_tick every 4th cycle; the second start bit loses one clock
    // because it begins the edge after the done tick, between oversampling ticks.
    tick_div = 4;
    send(8'hA3, 4'd8, 2'b00, 1'b0, "0110001011", 0, 1'b1, 1'b1);
    send(8'h3C, 4'd8, 2'b00, 1'b0, "0001111001", 1, 1'b0, 1'b0);
    wait_idle();
    tick_div = 1;
    idle_cycles(8, "idle_after_b2b");

    // Reset in data bit 3 of an 8N1 frame.
    send(8'h55, 4'd8, 2'b00, 1'b0, "0101010101", 0, 1'b0, 1'b0);
    repeat (72) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_tx", {31'd0, tx}, 32'd1);
    check("midreset_ready", {31'd0, tx_ready}, 32'd1);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, tx_done}, 32'd0);
    reset = 1'b0;
    idle_cycles(40, "idle_after_reset");
    send(8'h0F, 4'd8, 2'b00, 1'b0, "0111100001", 0, 1'b0, 1'b0);
    wait_idle();
    idle_cycles(4, "idle_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter. It is the successor to the fixed 8N1 transmitter in the UART core. It serialises one character per frame: start bit, 1..DATA_W data bits LSB first, an optional even/odd parity bit, then 1 or 2 stop bits. Bit timing comes from the shared baud-rate generator's oversampling tick. A ready/valid handshake replaces the single-pulse start strobe, so a FIFO can feed the block directly.

Parameters:
DATA_W, 8, maximum data bits per frame; legal range 5..15.
OS_TICK, 16, s_tick pulses per bit period; must be at least 2.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
s_tick  in  1  one-cycle oversampling tick from the baud generator
tx_valid  in  1  character available on tx_data
tx_ready  out  1  block can accept a character (high only in IDLE)
tx_data  in  DATA_W  character; bits above the configured length are ignored
cfg_dbits  in  4  data bits per frame; 0 or >DATA_W is treated as DATA_W
cfg_par  in  2  parity mode: 00/11 none, 01 even, 10 odd
cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits
tx  out  1  serial line, idle high
busy  out  1  frame in progress (state != IDLE)
tx_done_tick  out  1  one-cycle pulse when a frame completes

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high, sampled on the clk rising edge. It has priority over all other inputs.
- Reset values: state=IDLE, tx=1, tx_done_tick=0, busy=0, tx_ready=1. All internal counters and the shift register are 0.
- Reset mid-frame: tx returns to 1 on the next edge. The frame is abandoned and no tx_done_tick is produced.
- tx and tx_done_tick are registered outputs. tx_ready and busy are decoded from the state register only; there is no combinational path from inputs.
- Accept happens at the edge where tx_valid=1 and tx_ready=1. At that edge the block latches tx_data, cfg_dbits, cfg_par and cfg_stop2. Config changes mid-frame have no effect.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. On accept, go to START; the tick counter s and bit counter n clear to 0. tx=0 from the cycle after accept.
- START: tx=0. On each s_tick, s increments. On the s_tick where s==OS_TICK-1, s clears and the state moves to DATA. tx takes data bit 0 on the same edge.
- DATA: tx=current LSB of the shift register. On each s_tick, s increments.
  - At s==OS_TICK-1 with s_tick, the shift register shifts right and n increments.
  - If n==dbits-1, go to PARITY when parity is enabled, otherwise STOP.
  - tx takes the next bit, the parity bit, or 1 on the same edge.
- PARITY: tx = XOR of the latched data bits [dbits-1:0], inverted for odd parity. Lasts OS_TICK s_ticks, then goes to STOP with tx=1.
- STOP: tx=1. Lasts OS_TICK s_ticks for one stop bit or 2*OS_TICK for two. The tick counter is wide enough for 2*OS_TICK-1.
  - On the final s_tick, go to IDLE and register tx_done_tick=1 for exactly one cycle.
  - That cycle is the first cycle of IDLE, with tx_ready=1.
- Back-to-back frames: if tx_valid is held, the next accept happens in the tx_done_tick cycle. The next start bit begins on the following edge, with no extra idle bit.
- Cycles without s_tick hold all state. s_tick during IDLE is ignored.
- Frame length = (1 + dbits + parity_en + stop_bits) * OS_TICK s_ticks, measured from the first tx=0 cycle to the done edge.
- tx_valid without tx_ready (frame in progress) is ignored. tx_data need not stay stable after accept.

Test Plan:
- Reset then idle, s_tick every cycle, tx_valid=0 for 100 cycles -> tx=1, tx_ready=1, busy=0, tx_done_tick never asserted.
- 8N1 with tx_data=0x55, OS_TICK=16, s_tick every cycle:
  - tx=0 for 16 cycles, then bits 1,0,1,0,1,0,1,0 for 16 cycles each, then 1 for 16 cycles.
  - tx_done_tick pulses once, 160 cycles after the first tx=0 cycle.
- 8E1 with 0x55 -> parity bit 0, frame is 176 ticks. 8O1 with 0x55 -> parity bit 1.
- 7O2 with tx_data=0xC1 -> bit 7 ignored; data 1,0,0,0,0,0,1; parity 1; stop high for 32 ticks; done at 176 ticks.
- Back-to-back: tx_valid held high with 0xA3 then 0x3C, s_tick every 4th cycle:
  - second start bit begins the edge after the first tx_done_tick;
  - each bit lasts 64 clocks;
  - exactly two done pulses.
- Assert reset in DATA bit 3 of an 8N1 frame -> tx=1 and state IDLE on the next edge, no done pulse. A subsequent 0x0F frame transmits correctly.
